lut_ram_ctrl: RTL and testbench

- Front-end controller for one lut_ram instance (1 write port, 1 combinational read port).
- Shares the RAM between two requesters using round-robin arbitration, with valid/ready request and registered read response.
- Sequences a hardware clear sweep that zeroes every entry after reset or on clear_req.
- Sits between pipeline/debug clients and the lut_ram; owns all lut_ram input pins.

---
 rtl/lut_ram_ctrl_pkg.sv | 5 +
 rtl/lut_ram_ctrl_rr_arbiter.sv | 34 +++
 rtl/lut_ram_ctrl.sv | 105 ++++++++++
 tb/tb_lut_ram_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_ram_ctrl_pkg.sv
// rtl/lut_ram_ctrl_pkg.sv - shared types and constants for lut_ram_ctrl
package lut_ram_ctrl_pkg;
   typedef enum logic [1:0] {INIT, CLEAR, SERVE} ctrl_state_t;
   localparam int NUM_REQ = 2;
endpackage

// File: rtl/lut_ram_ctrl_rr_arbiter.sv
// rtl/lut_ram_ctrl_rr_arbiter.sv - two-way round-robin arbiter, one-hot grant
module rr_arbiter_2
   import lut_ram_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt
);
   logic rr_ptr;

   always_comb begin
      gnt = '0;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
            default: gnt = '0;
         endcase
      end
   end

   // Priority passes to the other requester after every grant; held when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= 1'b0;
      else if (gnt[0])
         rr_ptr <= 1'b1;
      else if (gnt[1])
         rr_ptr <= 1'b0;
   end
endmodule

// File: rtl/lut_ram_ctrl.sv
// rtl/lut_ram_ctrl.sv - lut_ram front end: clear sweep, two-way arbitration, read response
module lut_ram_ctrl
   import lut_ram_ctrl_pkg::*;
#(
   parameter  int LUT_WIDTH = 32,
   parameter  int LUT_DEPTH = 32,
   localparam int ADDR_W    = $clog2(LUT_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear_req,
   output logic                     busy,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ-1:0]       req_we,
   input  logic [2*ADDR_W-1:0]      req_addr,
   input  logic [2*LUT_WIDTH-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       rsp_valid,
   output logic [LUT_WIDTH-1:0]     rsp_rdata,
   output logic                     lut_wr_en,
   output logic [ADDR_W-1:0]        lut_wr_addr,
   output logic [LUT_WIDTH-1:0]     lut_wr_data,
   output logic [ADDR_W-1:0]        lut_rd_addr,
   input  logic [LUT_WIDTH-1:0]     lut_rd_data
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LUT_DEPTH - 1);

   ctrl_state_t            state_q, state_d;
   logic [ADDR_W-1:0]      clr_cnt_q, clr_cnt_d;
   logic [NUM_REQ-1:0]     gnt;
   logic [NUM_REQ-1:0]     rd_gnt;
   logic                   sel;
   logic                   gnt_any;
   logic                   gnt_we;
   logic [ADDR_W-1:0]      gnt_addr;
   logic [LUT_WIDTH-1:0]   gnt_wdata;

   rr_arbiter_2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (req_valid),
      .en  (state_q == SERVE),
      .gnt (gnt)
   );

   assign req_ready = gnt;
   assign sel       = gnt[1];
   assign gnt_any   = |gnt;
   assign gnt_we    = req_we[sel];
   assign gnt_addr  = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
   assign gnt_wdata = sel ? req_wdata[2*LUT_WIDTH-1:LUT_WIDTH] : req_wdata[LUT_WIDTH-1:0];
   assign rd_gnt    = gnt & ~req_we;

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      busy        = 1'b1;
      lut_wr_en   = 1'b0;
      lut_wr_addr = '0;
      lut_wr_data = '0;
      lut_rd_addr = '0;
      case (state_q)
         INIT: state_d = CLEAR;
         CLEAR: begin
            lut_wr_en   = 1'b1;
            lut_wr_addr = clr_cnt_q;
            if (clr_cnt_q == LAST_ADDR) begin
               state_d   = SERVE;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
         SERVE: begin
            busy = 1'b0;
            if (gnt_any && gnt_we) begin
               lut_wr_en   = 1'b1;
               lut_wr_addr = gnt_addr;
               lut_wr_data = gnt_wdata;
            end
            if (gnt_any && !gnt_we)
               lut_rd_addr = gnt_addr;
            // The op granted alongside clear_req still completes this cycle.
            if (clear_req)
               state_d = CLEAR;
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= INIT;
         clr_cnt_q <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         rsp_valid <= rd_gnt;
         if (|rd_gnt)
            rsp_rdata <= lut_rd_data;
      end
   end
endmodule

// File: tb/tb_lut_ram_ctrl.sv
// tb/tb_lut_ram_ctrl.sv - scoreboard bench for lut_ram_ctrl with a behavioural lut_ram
module tb_lut_ram_ctrl;
   localparam int W  = 32;
   localparam int D  = 16;
   localparam int AW = 4;

   typedef enum {M_INIT, M_CLEAR, M_SERVE} mode_t;
   typedef struct {
      int           due;
      logic [1:0]   who;
      logic [W-1:0] data;
   } rsp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            clear_req = 1'b0;
   logic            busy;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_we = '0;
   logic [2*AW-1:0] req_addr = '0;
   logic [2*W-1:0]  req_wdata = '0;
   logic [1:0]      req_ready;
   logic [1:0]      rsp_valid;
   logic [W-1:0]    rsp_rdata;
   logic            lut_wr_en;
   logic [AW-1:0]   lut_wr_addr;
   logic [W-1:0]    lut_wr_data;
   logic [AW-1:0]   lut_rd_addr;
   logic [W-1:0]    lut_rd_data;

   lut_ram_ctrl #(.LUT_WIDTH(W), .LUT_DEPTH(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .clear_req   (clear_req),
      .busy        (busy),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .lut_wr_en   (lut_wr_en),
      .lut_wr_addr (lut_wr_addr),
      .lut_wr_data (lut_wr_data),
      .lut_rd_addr (lut_rd_addr),
      .lut_rd_data (lut_rd_data)
   );

   always #5 clk = ~clk;

   logic [W-1:0] ram [D];
   initial for (int i = 0; i < D; i++) ram[i] <= 32'hA5A5_0000 | i;
   always @(posedge clk) if (lut_wr_en) ram[lut_wr_addr] <= lut_wr_data;
   assign lut_rd_data = ram[lut_rd_addr];

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           clr = 0;
   mode_t        mode = M_INIT;
   logic         rr = 1'b0;
   logic [W-1:0] mdl [D];
   logic [W-1:0] last_rdata = '0;
   rsp_t         q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] arb(input logic [1:0] v, input logic p);
      case (v)
         2'b01:   return 2'b01;
         2'b10:   return 2'b10;
         2'b11:   return p ? 2'b10 : 2'b01;
         default: return 2'b00;
      endcase
   endfunction

   task automatic set_req(input int i, input logic we, input int addr, input logic [W-1:0] data);
      req_valid[i]          = 1'b1;
      req_we[i]             = we;
      req_addr[i*AW +: AW]  = AW'(addr);
      req_wdata[i*W +: W]   = data;
   endtask

   task automatic idle();
      req_valid = '0;
      req_we    = '0;
      clear_req = 1'b0;
   endtask

   // One clock: check the due response and this cycle's expected outputs, then advance.
   task automatic step();
      logic [1:0]    eg;
      int            s;
      logic [AW-1:0] a;
      rsp_t          r;
      @(negedge clk);
      if (q.size() > 0 && q[0].due == cyc) begin
         r = q.pop_front();
         chk("rsp_valid", 64'(rsp_valid), 64'(r.who));
         chk("rsp_rdata", 64'(rsp_rdata), 64'(r.data));
         last_rdata = r.data;
      end else begin
         chk("rsp_idle", 64'(rsp_valid), 64'(0));
         chk("rsp_hold", 64'(rsp_rdata), 64'(last_rdata));
      end
      case (mode)
         M_INIT: begin
            chk("init_busy", 64'(busy), 64'(1));
            chk("init_wr_en", 64'(lut_wr_en), 64'(0));
            chk("init_ready", 64'(req_ready), 64'(0));
            mode = M_CLEAR;
            clr  = 0;
         end
         M_CLEAR: begin
            chk("clr_busy", 64'(busy), 64'(1));
            chk("clr_ready", 64'(req_ready), 64'(0));
            chk("clr_wr_en", 64'(lut_wr_en), 64'(1));
            chk("clr_wr_addr", 64'(lut_wr_addr), 64'(clr));
            chk("clr_wr_data", 64'(lut_wr_data), 64'(0));
            mdl[clr] = '0;
            if (clr == D - 1) begin
               mode = M_SERVE;
               clr  = 0;
            end else begin
               clr++;
            end
         end
         default: begin
            eg = arb(req_valid, rr);
            chk("srv_busy", 64'(busy), 64'(0));
            chk("srv_ready", 64'(req_ready), 64'(eg));
            if (eg != 2'b00) begin
               s  = eg[1] ? 1 : 0;
               a  = req_addr[s*AW +: AW];
               rr = (s == 0);
               if (req_we[s]) begin
                  chk("wr_en", 64'(lut_wr_en), 64'(1));
                  chk("wr_addr", 64'(lut_wr_addr), 64'(a));
                  chk("wr_data", 64'(lut_wr_data), 64'(req_wdata[s*W +: W]));
                  mdl[a] = req_wdata[s*W +: W];
               end else begin
                  chk("rd_wr_en", 64'(lut_wr_en), 64'(0));
                  chk("rd_addr", 64'(lut_rd_addr), 64'(a));
                  r.due  = cyc + 1;
                  r.who  = eg;
                  r.data = mdl[a];
                  q.push_back(r);
               end
            end else begin
               chk("idle_wr_en", 64'(lut_wr_en), 64'(0));
               chk("idle_rd_addr", 64'(lut_rd_addr), 64'(0));
            end
            if (clear_req) begin
               mode = M_CLEAR;
               clr  = 0;
            end
         end
      endcase
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < D; i++) mdl[i] = 'x;
      #1;
      chk("rst_busy", 64'(busy), 64'(1));
      chk("rst_wr_en", 64'(lut_wr_en), 64'(0));
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
      @(posedge clk);
      #1;
      rst  = 1'b0;
      mode = M_INIT;
      repeat (17) step();

      // Cleared entries read back as zero
      set_req(0, 1'b0, 3, '0);
      step();
      idle();
      set_req(1, 1'b0, 15, '0);
      step();
      idle();
      step();

      // Write then immediate read of the same address
      set_req(0, 1'b1, 5, 32'hDEAD_BEEF);
      step();
      idle();
      set_req(1, 1'b0, 5, '0);
      step();
      idle();
      step();
      step();

      // Preload then contend continuously
      set_req(0, 1'b1, 1, 32'h11);
      step();
      idle();
      set_req(1, 1'b1, 2, 32'h22);
      step();
      idle();
      set_req(0, 1'b0, 1, '0);
      set_req(1, 1'b0, 2, '0);
      repeat (6) step();
      idle();
      step();

      // Lone requester, back-to-back reads
      for (int i = 0; i < 4; i++) begin
         set_req(1, 1'b0, i, '0);
         step();
      end
      idle();
      step();

      // clear_req together with a read: read completes, response lands in first CLEAR cycle
      set_req(0, 1'b0, 5, '0);
      clear_req = 1'b1;
      step();
      idle();
      repeat (16) step();
      set_req(0, 1'b0, 5, '0);
      step();
      idle();
      step();

      // Async reset mid-sweep
      set_req(0, 1'b1, 7, 32'h1234_5678);
      step();
      idle();
      set_req(0, 1'b0, 7, '0);
      clear_req = 1'b1;
      step();
      idle();
      repeat (8) step();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", 64'(busy), 64'(1));
      chk("arst_wr_en", 64'(lut_wr_en), 64'(0));
      chk("arst_ready", 64'(req_ready), 64'(0));
      chk("arst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("arst_rsp_rdata", 64'(rsp_rdata), 64'(0));
      q.delete();
      rr         = 1'b0;
      last_rdata = '0;
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      mode = M_CLEAR;
      clr  = 0;
      repeat (16) step();
      set_req(1, 1'b0, 7, '0);
      set_req(0, 1'b0, 9, '0);
      step();
      step();
      idle();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
